// File: rtl/mem_line_pkg.sv
// Shared types and defaults for the cache-to-memory line responder.
package mem_line_pkg;

  localparam int ADDR_W_DEF     = 28;
  localparam int DATA_W_DEF     = 128;
  localparam int DEPTH_LOG2_DEF = 6;
  localparam int CNT_W          = 16;

  // Responder FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Statistics counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == {CNT_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_line_ram.sv
// Line-addressed backing store: synchronous write, synchronous clear,
// combinational read.
module mem_line_ram
  import mem_line_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] lines_r [DEPTH];

  // Clear every line on reset, otherwise store the committed write line.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        lines_r[i] <= '0;
      end
    end else if (we) begin
      lines_r[idx] <= wdata;
    end
  end

  assign rdata = lines_r[idx];

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder for the cache line interface: accepts one read or
// write at a time and completes it with a one-cycle mem_ready pulse a fixed
// LATENCY cycles after acceptance.
module mem_line_responder
  import mem_line_pkg::*;
#(
  parameter int LATENCY    = 8,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic              proto_err
);

  // LATENCY=1 skips WAIT entirely; otherwise WAIT lasts LATENCY-1 cycles.
  localparam bit       LAT_ONE   = (LATENCY == 1);
  localparam logic [7:0] WAIT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  state_t              state_r;
  logic [7:0]          cnt_r;
  logic                write_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                mem_ready_r;
  logic [DATA_W-1:0]   mem_rdata_r;
  logic [CNT_W-1:0]    rd_count_r;
  logic [CNT_W-1:0]    wr_count_r;
  logic                proto_err_r;

  logic                req_s;
  logic                commit_s;
  logic                commit_write_s;
  logic [ADDR_W-1:0]   commit_addr_s;
  logic [DATA_W-1:0]   commit_wdata_s;
  logic                viol_s;
  logic [DATA_W-1:0]   ram_rdata_s;

  assign req_s = mem_read | mem_write;

  // Decide whether this edge commits an operation (the edge into RESP) and
  // which op/addr/data it uses; with LATENCY=1 the commit coincides with
  // acceptance so the live inputs are used instead of the latched copies.
  always_comb begin
    commit_s       = 1'b0;
    commit_write_s = write_r;
    commit_addr_s  = addr_r;
    commit_wdata_s = wdata_r;
    viol_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        commit_s       = req_s & LAT_ONE;
        commit_write_s = mem_write;
        commit_addr_s  = mem_addr;
        commit_wdata_s = mem_wdata;
        viol_s         = mem_read & mem_write;
      end
      ST_WAIT: begin
        if (cnt_r == 8'd0) begin
          commit_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
        // The master must keep exactly the latched op and address asserted.
        viol_s = (mem_write != write_r) || (mem_read != ~write_r) ||
                 (mem_addr != addr_r);
      end
      default: begin
        commit_s = 1'b0;
        viol_s   = 1'b0;
      end
    endcase
  end

  mem_line_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .clear (proc_reset),
    .we    (commit_s & commit_write_s),
    .idx   (commit_addr_s[DEPTH_LOG2-1:0]),
    .wdata (commit_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Responder FSM, latency counter, read-data/statistics commit and the
  // sticky protocol flag; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      write_r     <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      mem_ready_r <= 1'b0;
      mem_rdata_r <= '0;
      rd_count_r  <= '0;
      wr_count_r  <= '0;
      proto_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            write_r <= mem_write;
            addr_r  <= mem_addr;
            wdata_r <= mem_wdata;
            if (LAT_ONE) begin
              state_r <= ST_RESP;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= WAIT_INIT;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 8'd0) begin
            state_r <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      // mem_ready is high exactly in the cycle following a commit (RESP).
      mem_ready_r <= commit_s;

      if (commit_s) begin
        if (commit_write_s) begin
          wr_count_r <= sat_inc(wr_count_r);
        end else begin
          rd_count_r  <= sat_inc(rd_count_r);
          mem_rdata_r <= ram_rdata_s;
        end
      end

      if (viol_s) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  assign mem_ready = mem_ready_r;
  assign mem_rdata = mem_rdata_r;
  assign rd_count  = rd_count_r;
  assign wr_count  = wr_count_r;
  assign proto_err = proto_err_r;

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench: two responders (LATENCY 8 and 1) driven by a
// transaction-level master and compared against a behavioural line store.
module tb_mem_line_responder;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         mem_read;
  logic         mem_write;
  logic         sel;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;

  logic         rdy8, rdy1, err8, err1;
  logic [127:0] rdata8, rdata1;
  logic [15:0]  rdc8, rdc1, wrc8, wrc1;

  always #5 clk = ~clk;

  mem_line_responder #(.LATENCY(8)) dut8 (
    .clk(clk), .proc_reset(proc_reset),
    .mem_read(mem_read & ~sel), .mem_write(mem_write & ~sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(rdy8), .mem_rdata(rdata8),
    .rd_count(rdc8), .wr_count(wrc8), .proto_err(err8)
  );

  mem_line_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .proc_reset(proc_reset),
    .mem_read(mem_read & sel), .mem_write(mem_write & sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(rdy1), .mem_rdata(rdata1),
    .rd_count(rdc1), .wr_count(wrc1), .proto_err(err1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: per-DUT line store, last read line, counters, flag.
  logic [127:0] ref_mem   [2][64];
  logic [127:0] ref_rdata [2];
  int           ref_rd    [2];
  int           ref_wr    [2];
  logic         ref_err   [2];

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic o_ready(input bit s);
    return s ? rdy1 : rdy8;
  endfunction
  function automatic logic [127:0] o_rdata(input bit s);
    return s ? rdata1 : rdata8;
  endfunction
  function automatic logic [15:0] o_rdc(input bit s);
    return s ? rdc1 : rdc8;
  endfunction
  function automatic logic [15:0] o_wrc(input bit s);
    return s ? wrc1 : wrc8;
  endfunction
  function automatic logic o_err(input bit s);
    return s ? err1 : err8;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 64; i++) ref_mem[s][i] = '0;
      ref_rdata[s] = '0;
      ref_rd[s]    = 0;
      ref_wr[s]    = 0;
      ref_err[s]   = 1'b0;
    end
  endtask

  // One-cycle reset pulse; both responders must come out fully cleared.
  task automatic do_reset();
    proc_reset = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    step();
    proc_reset = 1'b0;
    model_clear();
    for (int s = 0; s < 2; s++) begin
      check_val("rst_ready", 128'(o_ready(s)), 128'd0);
      check_val("rst_rdata", o_rdata(s), 128'd0);
      check_val("rst_rdcnt", 128'(o_rdc(s)), 128'd0);
      check_val("rst_wrcnt", 128'(o_wrc(s)), 128'd0);
      check_val("rst_err",   128'(o_err(s)), 128'd0);
    end
  endtask

  // Master-side transaction: called in an IDLE cycle N, raises the request,
  // expects mem_ready exactly in cycle N+latency, then drops the request
  // (unless hold) and returns in cycle N+latency+1.
  // pert: 0 none, 1 change address in WAIT, 2 drop request for one WAIT cycle.
  task automatic do_op(input bit s, input bit wr, input bit both,
                       input logic [27:0] a, input logic [127:0] d,
                       input int pert, input bit hold);
    int  lat;
    bit  is_wr;
    lat   = s ? 1 : 8;
    is_wr = wr | both;
    sel       = s;
    mem_addr  = a;
    mem_wdata = d;
    mem_write = is_wr;
    mem_read  = ~wr | both;
    check_val("idle_ready", 128'(o_ready(s)), 128'd0);
    for (int k = 1; k <= lat; k++) begin
      step();
      if (k < lat) begin
        check_val("early_ready", 128'(o_ready(s)), 128'd0);
        if (lat > 2 && k == 1 && pert == 1) mem_addr = a ^ 28'h15;
        if (lat > 2 && k == 1 && pert == 2) begin
          mem_read  = 1'b0;
          mem_write = 1'b0;
        end
        if (lat > 2 && k == 2 && pert == 2) begin
          mem_write = is_wr;
          mem_read  = ~wr | both;
        end
      end else begin
        if (is_wr) begin
          ref_mem[s][a[5:0]] = d;
          ref_wr[s]++;
        end else begin
          ref_rdata[s] = ref_mem[s][a[5:0]];
          ref_rd[s]++;
        end
        if (both || (pert != 0 && lat > 2)) ref_err[s] = 1'b1;
        check_val("resp_ready", 128'(o_ready(s)), 128'd1);
        check_val("resp_rdata", o_rdata(s), ref_rdata[s]);
        check_val("resp_rdcnt", 128'(o_rdc(s)), 128'(ref_rd[s]));
        check_val("resp_wrcnt", 128'(o_wrc(s)), 128'(ref_wr[s]));
        check_val("resp_err",   128'(o_err(s)), 128'(ref_err[s]));
        if (!hold) begin
          mem_read  = 1'b0;
          mem_write = 1'b0;
        end
      end
    end
    step();
    check_val("post_ready", 128'(o_ready(s)), 128'd0);
    check_val("post_rdata", o_rdata(s), ref_rdata[s]);
  endtask

  initial begin
    logic [127:0] d;
    logic [27:0]  a;
    int           pert;
    proc_reset = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    sel        = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    step();
    step();
    do_reset();

    // Read of a cleared line.
    do_op(1'b0, 1'b0, 1'b0, 28'h0000005, 128'h0, 0, 1'b0);

    // Write then read back the same line.
    d = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    do_op(1'b0, 1'b1, 1'b0, 28'h0000012, d, 0, 1'b0);
    do_op(1'b0, 1'b0, 1'b0, 28'h0000012, 128'h0, 0, 1'b0);

    // LATENCY=1: request held through RESP is re-accepted in N+2.
    do_op(1'b1, 1'b1, 1'b0, 28'h0000007, 128'hA5A5, 0, 1'b1);
    do_op(1'b1, 1'b0, 1'b0, 28'h0000007, 128'h0, 0, 1'b1);
    do_op(1'b1, 1'b0, 1'b0, 28'h0000007, 128'h0, 0, 1'b0);

    // Aliasing: upper address bits are ignored.
    do_op(1'b0, 1'b1, 1'b0, 28'h0000040, 128'h1, 0, 1'b0);
    do_op(1'b0, 1'b0, 1'b0, 28'h0000000, 128'h0, 0, 1'b0);

    // Read+write together, then address moved in WAIT: write lands at the
    // latched address and the flag stays set.
    do_op(1'b0, 1'b1, 1'b1, 28'h0000021, 128'h77, 1, 1'b0);
    do_op(1'b0, 1'b0, 1'b0, 28'h0000021, 128'h0, 0, 1'b0);
    do_op(1'b0, 1'b0, 1'b0, 28'h0000034, 128'h0, 0, 1'b0);

    // Reset in the middle of WAIT of a write to line 3.
    sel       = 1'b0;
    mem_addr  = 28'h0000003;
    mem_wdata = 128'hFFFF_0000_1234;
    mem_write = 1'b1;
    mem_read  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("pre_rst_ready", 128'(rdy8), 128'd0);
    end
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      check_val("drop_ready", 128'(rdy8), 128'd0);
    end
    do_op(1'b0, 1'b0, 1'b0, 28'h0000003, 128'h0, 0, 1'b0);

    // Randomized traffic on both responders.
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 19) == 0) do_reset();
      a    = {22'($urandom()), 6'($urandom_range(0, 7))};
      d    = {$urandom(), $urandom(), $urandom(), $urandom()};
      pert = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), a, d, pert, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side responder for the cache-to-memory line interface: serves mem_read and mem_write requests from the cache controller.
- Responds with a single-cycle mem_ready pulse after a fixed, programmable latency.
- Holds a small line-addressed backing store of 128-bit lines.
- Used as the memory model in cache benches and as the template for the real memory controller.

Parameters:
- LATENCY, 8, cycles from request acceptance to the mem_ready pulse; legal range 1..255.
- ADDR_W, 28, line address width (word address without the 2 word-offset bits).
- DATA_W, 128, line width (4 x 32-bit words).
- DEPTH_LOG2, 6, log2 of stored lines; index = mem_addr[DEPTH_LOG2-1:0]. Upper address bits are ignored, so addresses alias.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- proc_reset  input  1  synchronous active-high reset.
- mem_read  input  1  read request; held by the master until it sees mem_ready.
- mem_write  input  1  write request; held by the master until it sees mem_ready.
- mem_addr  input  ADDR_W  line address; stable while a request is held.
- mem_wdata  input  DATA_W  write line; stable while mem_write is held.
- mem_ready  output  1  one-cycle completion pulse.
- mem_rdata  output  DATA_W  read line; valid while mem_ready=1 after a read.
- rd_count  output  16  completed reads, saturating at 16'hFFFF.
- wr_count  output  16  completed writes, saturating at 16'hFFFF.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (proc_reset=1 at posedge):
  - state=IDLE; mem_ready=0, mem_rdata=0, rd_count=0, wr_count=0, proto_err=0.
  - All stored lines are cleared to 0.
  - Reset overrides everything, including an in-flight operation; that operation is dropped with no ready pulse and no store update.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read|mem_write is sampled high, the request is accepted: op (write has priority), addr and wdata are latched.
  - If LATENCY=1, go to RESP. Otherwise go to WAIT with cnt=LATENCY-2.
- WAIT:
  - While cnt!=0, decrement cnt.
  - When cnt==0, go to RESP.
- Commit on the edge into RESP:
  - Read: mem_rdata <= line[idx].
  - Write: line[idx] <= latched wdata.
  - The matching counter increments unless already saturated.
- RESP:
  - mem_ready=1 for exactly this one cycle; mem_ready is a registered output, i.e. mem_ready==(state==RESP).
  - Next state is always IDLE. Requests present in RESP are not accepted; the master drops its request combinationally on mem_ready.
- Latency: request first high in cycle N (state IDLE) gives mem_ready high in cycle N+LATENCY.
- Back-to-back operations: earliest new acceptance is the cycle after RESP.
  - A write followed by a read of the same line returns the new data.
- mem_rdata holds its value until the next read commit; it is not cleared after the pulse.
  - After a write, mem_rdata keeps the previous read value.
- proto_err is set (sticky until reset) when any of these occurs:
  - mem_read and mem_write are sampled high together at acceptance (the write is still served);
  - in WAIT, the request is deasserted, or mem_addr differs from the latched addr, or the op changes.
- Violations do not abort the operation: it completes with the latched values and still pulses mem_ready.

Decomposition:
- Package mem_line_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - ADDR_W/DATA_W defaults and the counter width (16).
- One sub-module, mem_line_ram: DEPTH-entry x DATA_W storage with synchronous write, synchronous clear-on-reset and combinational read. The responder FSM, latency counter and statistics stay in the top module.

Test Plan:
- Reset then read addr 28'h0000005 with LATENCY=8, request first high in cycle 10 -> mem_ready high only in cycle 18, mem_rdata=128'h0, rd_count=1, proto_err=0.
- Write 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D to addr 28'h0000012, then read the same addr -> read returns that exact line, wr_count=1, rd_count=1, each mem_ready exactly one cycle wide.
- LATENCY=1: read asserted in cycle N -> mem_ready in cycle N+1. Request held through RESP -> no second acceptance in RESP; the next acceptance occurs in cycle N+2 only if the request is still high.
- Aliasing with DEPTH_LOG2=6: write 128'h1 to addr 28'h0000040, read addr 28'h0000000 -> returns 128'h1.
- mem_read and mem_write both high, then mem_addr changed during WAIT -> write is committed to the originally latched addr, mem_ready pulses on schedule, proto_err=1 and stays 1 until proc_reset.
- proc_reset asserted in the middle of WAIT of a write to addr 3 -> no mem_ready pulse, line 3 reads back 0, counters 0, state IDLE the cycle after reset is released.
